// File: rtl/pxl_st_src.sv
//==============================================================================
// Module   : pxl_st_src
// Purpose  : Frame-memory to pixel-stream source. On Start it reads a
//            width x height frame from word-addressed memory in raster order
//            and presents each pixel with its X/Y on a valid/ready stream.
//            A 3-entry FIFO decouples the fixed-latency memory from the sink.
// Ports    : Clk, Reset          - clock, synchronous active-high reset
//            Start               - frame request (honoured only in IDLE)
//            ImgWidth/ImgHeight  - frame size, latched at Start
//            ImgBaseAddr         - word address of pixel (0,0), latched at Start
//            Busy, Done          - frame in progress / completion pulse
//            MemRdEn, MemRdAddr  - memory read request
//            MemRdData           - read data, valid one cycle after MemRdEn
//            PxlData/PxlX/PxlY   - pixel colours and coordinates
//            PxlVld, PxlRdy      - stream handshake
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module pxl_st_src #(
  parameter int PXL_PRIM_COLOR_W   = 8,
  parameter int PXL_PRIM_COLOR_NUM = 3,
  parameter int IMG_WIDTH_IDX_W    = 11,
  parameter int IMG_HEIGHT_IDX_W   = 11,
  parameter int MEM_ADDR_W         = 22
) (
  input  logic                                         Clk,
  input  logic                                         Reset,
  input  logic                                         Start,
  input  logic [IMG_WIDTH_IDX_W-1:0]                   ImgWidth,
  input  logic [IMG_HEIGHT_IDX_W-1:0]                  ImgHeight,
  input  logic [MEM_ADDR_W-1:0]                        ImgBaseAddr,
  output logic                                         Busy,
  output logic                                         Done,
  output logic                                         MemRdEn,
  output logic [MEM_ADDR_W-1:0]                        MemRdAddr,
  input  logic [PXL_PRIM_COLOR_W*PXL_PRIM_COLOR_NUM-1:0] MemRdData,
  output logic [PXL_PRIM_COLOR_W-1:0]                  PxlData [PXL_PRIM_COLOR_NUM],
  output logic [IMG_WIDTH_IDX_W-1:0]                   PxlX,
  output logic [IMG_HEIGHT_IDX_W-1:0]                  PxlY,
  output logic                                         PxlVld,
  input  logic                                         PxlRdy
);

  localparam int c_DATA_W = PXL_PRIM_COLOR_W * PXL_PRIM_COLOR_NUM;

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_RUN   = 2'd1;
  localparam logic [1:0] c_ST_DRAIN = 2'd2;

  localparam logic [IMG_WIDTH_IDX_W-1:0]  c_X_ONE    = 1;
  localparam logic [IMG_HEIGHT_IDX_W-1:0] c_Y_ONE    = 1;
  localparam logic [MEM_ADDR_W-1:0]       c_ADDR_ONE = 1;

  // Control state
  logic [1:0]                  r_state;
  logic [IMG_WIDTH_IDX_W-1:0]  r_width;
  logic [IMG_HEIGHT_IDX_W-1:0] r_height;
  logic [IMG_WIDTH_IDX_W-1:0]  r_rd_x;
  logic [IMG_HEIGHT_IDX_W-1:0] r_rd_y;
  logic [MEM_ADDR_W-1:0]       r_rd_addr;
  logic                        r_done;

  // Coordinates of the read whose data is on MemRdData this cycle
  logic                        r_ret_vld;
  logic [IMG_WIDTH_IDX_W-1:0]  r_ret_x;
  logic [IMG_HEIGHT_IDX_W-1:0] r_ret_y;

  // Pixel FIFO
  logic [c_DATA_W-1:0]         r_fifo_data [0:2];
  logic [IMG_WIDTH_IDX_W-1:0]  r_fifo_x    [0:2];
  logic [IMG_HEIGHT_IDX_W-1:0] r_fifo_y    [0:2];
  logic [1:0]                  r_wr_ptr;
  logic [1:0]                  r_rd_ptr;
  logic [1:0]                  r_fifo_cnt;

  logic                        w_dims_ok;
  logic                        w_credit_ok;
  logic                        w_rd_en;
  logic                        w_rd_last;
  logic                        w_push;
  logic                        w_pop;
  logic                        w_last_pop;
  logic [c_DATA_W-1:0]         w_head_data;

  assign w_dims_ok = (ImgWidth != '0) && (ImgHeight != '0);

  // Credit check uses only registered state so PxlRdy never reaches MemRdEn
  // combinationally. Entries held plus the read returning this cycle must
  // leave room for the read about to be issued.
  assign w_credit_ok = ({1'b0, r_fifo_cnt} + {2'b00, r_ret_vld}) < 3'd3;
  assign w_rd_en     = (r_state == c_ST_RUN) && w_credit_ok;
  assign w_rd_last   = (r_rd_x == (r_width - c_X_ONE)) &&
                       (r_rd_y == (r_height - c_Y_ONE));

  assign w_push = r_ret_vld;
  assign w_pop  = (r_fifo_cnt != 2'd0) && PxlRdy;

  // In DRAIN every read has been issued; the frame ends when the single
  // remaining entry leaves and nothing is still returning from memory.
  assign w_last_pop = w_pop && (r_fifo_cnt == 2'd1) && !r_ret_vld;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= c_ST_IDLE;
      r_width   <= '0;
      r_height  <= '0;
      r_rd_x    <= '0;
      r_rd_y    <= '0;
      r_rd_addr <= '0;
      r_done    <= 1'b0;
      r_ret_vld <= 1'b0;
      r_ret_x   <= '0;
      r_ret_y   <= '0;
    end else begin
      r_done    <= 1'b0;
      r_ret_vld <= w_rd_en;
      r_ret_x   <= r_rd_x;
      r_ret_y   <= r_rd_y;
      case (r_state)
        c_ST_IDLE: begin
          if (Start) begin
            if (w_dims_ok) begin
              r_width   <= ImgWidth;
              r_height  <= ImgHeight;
              r_rd_x    <= '0;
              r_rd_y    <= '0;
              r_rd_addr <= ImgBaseAddr;
              r_state   <= c_ST_RUN;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        c_ST_RUN: begin
          if (w_rd_en) begin
            // Raster order makes Y*W+X contiguous, so the address just counts.
            r_rd_addr <= r_rd_addr + c_ADDR_ONE;
            if (r_rd_x == (r_width - c_X_ONE)) begin
              r_rd_x <= '0;
              r_rd_y <= r_rd_y + c_Y_ONE;
            end else begin
              r_rd_x <= r_rd_x + c_X_ONE;
            end
            if (w_rd_last) begin
              r_state <= c_ST_DRAIN;
            end
          end
        end
        c_ST_DRAIN: begin
          if (w_last_pop) begin
            r_state <= c_ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == 2'd2) ? 2'd0 : r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == 2'd2) ? 2'd0 : r_rd_ptr + 2'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // FIFO storage needs no reset: outputs are forced to zero while empty.
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= MemRdData;
      r_fifo_x[r_wr_ptr]    <= r_ret_x;
      r_fifo_y[r_wr_ptr]    <= r_ret_y;
    end
  end

  assign w_head_data = r_fifo_data[r_rd_ptr];

  assign Busy      = (r_state != c_ST_IDLE);
  assign Done      = r_done;
  assign MemRdEn   = w_rd_en;
  assign MemRdAddr = r_rd_addr;
  assign PxlVld    = (r_fifo_cnt != 2'd0);
  assign PxlX      = PxlVld ? r_fifo_x[r_rd_ptr] : '0;
  assign PxlY      = PxlVld ? r_fifo_y[r_rd_ptr] : '0;

  for (genvar gi = 0; gi < PXL_PRIM_COLOR_NUM; gi++) begin : g_pxl_color
    assign PxlData[gi] = PxlVld ? w_head_data[gi*PXL_PRIM_COLOR_W +: PXL_PRIM_COLOR_W] : '0;
  end

endmodule

`default_nettype wire

// File: tb/tb_pxl_st_src.sv
//==============================================================================
// Module   : tb_pxl_st_src
// Purpose  : Self-checking bench for pxl_st_src. A memory model returns a
//            hashed word per address; an expected-pixel queue built from the
//            frame geometry is compared against every handshake.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pxl_st_src;

  localparam int CW = 8;
  localparam int CN = 3;
  localparam int XW = 11;
  localparam int YW = 11;
  localparam int AW = 22;
  localparam int DW = CW * CN;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Start;
  logic [XW-1:0] ImgWidth;
  logic [YW-1:0] ImgHeight;
  logic [AW-1:0] ImgBaseAddr;
  logic          Busy;
  logic          Done;
  logic          MemRdEn;
  logic [AW-1:0] MemRdAddr;
  logic [DW-1:0] MemRdData;
  logic [CW-1:0] PxlData [CN];
  logic [XW-1:0] PxlX;
  logic [YW-1:0] PxlY;
  logic          PxlVld;
  logic          PxlRdy;

  always #5 Clk = ~Clk;

  pxl_st_src #(
    .PXL_PRIM_COLOR_W   (CW),
    .PXL_PRIM_COLOR_NUM (CN),
    .IMG_WIDTH_IDX_W    (XW),
    .IMG_HEIGHT_IDX_W   (YW),
    .MEM_ADDR_W         (AW)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .ImgWidth    (ImgWidth),
    .ImgHeight   (ImgHeight),
    .ImgBaseAddr (ImgBaseAddr),
    .Busy        (Busy),
    .Done        (Done),
    .MemRdEn     (MemRdEn),
    .MemRdAddr   (MemRdAddr),
    .MemRdData   (MemRdData),
    .PxlData     (PxlData),
    .PxlX        (PxlX),
    .PxlY        (PxlY),
    .PxlVld      (PxlVld),
    .PxlRdy      (PxlRdy)
  );

  // Memory contents: a fixed hash of the word address.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    logic [31:0] h;
    h = {10'd0, a} * 32'h9E37_79B1;
    h = h ^ (h >> 13);
    return h[DW-1:0];
  endfunction

  // One-cycle read latency memory: request seen mid-cycle, data driven just
  // after the following edge; garbage when no read is pending.
  logic          mm_en = 1'b0;
  logic [AW-1:0] mm_addr = '0;
  always @(negedge Clk) begin
    mm_en   = MemRdEn;
    mm_addr = MemRdAddr;
  end
  always @(posedge Clk) begin
    #1;
    MemRdData = mm_en ? mem_word(mm_addr) : DW'($urandom);
  end

  typedef struct {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [DW-1:0] d;
  } pix_t;

  typedef struct {
    int            w;
    int            h;
    logic [AW-1:0] base;
    int            mode;
    int            exp_pix;
    int            exp_done;
  } vec_t;

  pix_t          exp_pix[$];
  logic [AW-1:0] exp_addr[$];

  int   total = 0;
  int   bad = 0;
  int   pix_got = 0;
  int   done_cnt = 0;
  int   reads_cnt = 0;
  int   pops_cnt = 0;
  bit   last_hs = 1'b0;
  bit   prev_stall = 1'b0;
  pix_t prev_head;
  int   rdy_mode = 0;
  bit   rdy_force = 1'b0;
  int   bub = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pxl_word();
    logic [DW-1:0] w;
    for (int i = 0; i < CN; i++) w[i*CW +: CW] = PxlData[i];
    return w;
  endfunction

  task automatic drive_rdy();
    case (rdy_mode)
      0: PxlRdy = 1'b1;
      1: begin
        if (bub > 0) begin
          PxlRdy = 1'b0;
          bub--;
        end else begin
          PxlRdy = 1'b1;
          if ($urandom_range(0, 3) == 0) bub = $urandom_range(1, 2);
        end
      end
      default: PxlRdy = rdy_force;
    endcase
  endtask

  // Observes one cycle; a handshake seen here completes at the next edge.
  task automatic monitor();
    pix_t hd;
    logic [DW-1:0] w;
    w = pxl_word();
    if (last_hs) begin
      check("done_after_last_pixel", Done, 1);
      check("busy_low_with_done", Busy, 0);
      last_hs = 1'b0;
    end
    if (Done) done_cnt++;
    if (prev_stall) begin
      check("hold_vld", PxlVld, 1);
      check("hold_x", PxlX, prev_head.x);
      check("hold_y", PxlY, prev_head.y);
      check("hold_data", w, prev_head.d);
    end
    if (MemRdEn) begin
      reads_cnt++;
      if (exp_addr.size() == 0) check("unexpected_read", MemRdEn, 0);
      else check("rd_addr", MemRdAddr, exp_addr.pop_front());
      check("rd_outstanding_le3", (reads_cnt - pops_cnt) <= 3, 1);
    end
    if (PxlVld) begin
      if (exp_pix.size() == 0) begin
        check("unexpected_pxl", PxlVld, 0);
      end else if (PxlRdy) begin
        hd = exp_pix.pop_front();
        check("pxl_x", PxlX, hd.x);
        check("pxl_y", PxlY, hd.y);
        check("pxl_data", w, hd.d);
        pix_got++;
        pops_cnt++;
        if (exp_pix.size() == 0) last_hs = 1'b1;
      end
    end
    prev_stall  = PxlVld && !PxlRdy;
    prev_head.x = PxlX;
    prev_head.y = PxlY;
    prev_head.d = w;
  endtask

  task automatic tick();
    @(negedge Clk);
    drive_rdy();
    monitor();
  endtask

  task automatic start_frame(input int w, input int h, input logic [AW-1:0] base);
    logic [AW-1:0] a;
    pix_t p;
    if (w != 0 && h != 0) begin
      for (int y = 0; y < h; y++) begin
        for (int x = 0; x < w; x++) begin
          a   = base + AW'(y * w + x);
          p.x = XW'(x);
          p.y = YW'(y);
          p.d = mem_word(a);
          exp_addr.push_back(a);
          exp_pix.push_back(p);
        end
      end
    end
    reads_cnt   = 0;
    pops_cnt    = 0;
    ImgWidth    = XW'(w);
    ImgHeight   = YW'(h);
    ImgBaseAddr = base;
    Start       = 1'b1;
    tick();
    Start       = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, input string name);
    int n;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    check(name, done_cnt - d0, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, Busy, 0);
    check({tag, "_done"}, Done, 0);
    check({tag, "_rden"}, MemRdEn, 0);
    check({tag, "_vld"}, PxlVld, 0);
    check({tag, "_addr"}, MemRdAddr, 0);
    check({tag, "_x"}, PxlX, 0);
    check({tag, "_y"}, PxlY, 0);
    check({tag, "_data"}, pxl_word(), 0);
  endtask

  vec_t tbl[7];

  initial begin
    int p0;
    int d0;
    int n;

    tbl[0] = '{w: 4,   h: 2,  base: 22'h000100, mode: 0, exp_pix: 8,    exp_done: 1};
    tbl[1] = '{w: 128, h: 64, base: 22'h02A000, mode: 1, exp_pix: 8192, exp_done: 1};
    tbl[2] = '{w: 1,   h: 1,  base: 22'h3FFFFE, mode: 1, exp_pix: 1,    exp_done: 1};
    tbl[3] = '{w: 7,   h: 3,  base: 22'h3FFFF8, mode: 1, exp_pix: 21,   exp_done: 1};
    tbl[4] = '{w: 0,   h: 5,  base: 22'h000010, mode: 0, exp_pix: 0,    exp_done: 1};
    tbl[5] = '{w: 3,   h: 0,  base: 22'h000020, mode: 1, exp_pix: 0,    exp_done: 1};
    tbl[6] = '{w: 1,   h: 9,  base: 22'h000055, mode: 1, exp_pix: 9,    exp_done: 1};

    Reset       = 1'b1;
    Start       = 1'b0;
    ImgWidth    = '0;
    ImgHeight   = '0;
    ImgBaseAddr = '0;
    PxlRdy      = 1'b0;

    // Reset state
    repeat (3) tick();
    check_idle_outputs("reset");
    Reset = 1'b0;
    tick();

    // Latency and back-to-back addresses, 4x2 at 0x100, sink always ready
    rdy_mode = 0;
    d0 = done_cnt;
    p0 = pix_got;
    start_frame(4, 2, 22'h000100);
    check("lat_rden_c1", MemRdEn, 1);
    check("lat_addr_c1", MemRdAddr, 22'h000100);
    check("lat_vld_c1", PxlVld, 0);
    check("lat_busy_c1", Busy, 1);
    tick();
    check("lat_rden_c2", MemRdEn, 1);
    check("lat_vld_c2", PxlVld, 0);
    tick();
    check("lat_vld_c3", PxlVld, 1);
    check("lat_x_c3", PxlX, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rden_streak", MemRdEn, 1);
    end
    tick();
    check("rden_after_last", MemRdEn, 0);
    wait_done(d0, 20, "seq_4x2_done");
    check("seq_4x2_pixels", pix_got - p0, 8);

    // Sink stalled for 6 cycles after the first valid pixel
    rdy_mode  = 2;
    rdy_force = 1'b0;
    d0 = done_cnt;
    p0 = pix_got;
    start_frame(4, 2, 22'h000200);
    n = 0;
    while (!PxlVld && n < 10) begin
      tick();
      n++;
    end
    check("stall_first_vld", PxlVld, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("stall_head_vld", PxlVld, 1);
      check("stall_head_x", PxlX, 0);
      check("stall_head_y", PxlY, 0);
    end
    check("stall_reads_le3", reads_cnt <= 3, 1);
    check("stall_reads_nonzero", reads_cnt > 0, 1);
    rdy_mode = 0;
    wait_done(d0, 40, "stall_done");
    check("stall_pixels", pix_got - p0, 8);

    // Start with zero width: immediate Done, no traffic
    d0 = done_cnt;
    start_frame(0, 5, 22'h000400);
    check("zero_done_pulse", Done, 1);
    check("zero_busy", Busy, 0);
    check("zero_rden", MemRdEn, 0);
    tick();
    check("zero_done_single", Done, 0);
    repeat (4) tick();
    check("zero_done_count", done_cnt - d0, 1);

    // Start during RUN with a different geometry is ignored
    rdy_mode = 1;
    d0 = done_cnt;
    p0 = pix_got;
    start_frame(4, 2, 22'h000040);
    repeat (2) tick();
    ImgWidth    = 11'd9;
    ImgHeight   = 11'd9;
    ImgBaseAddr = 22'h000000;
    Start       = 1'b1;
    tick();
    Start       = 1'b0;
    wait_done(d0, 60, "restart_ignored_done");
    repeat (5) tick();
    check("restart_pixels", pix_got - p0, 8);
    check("restart_done_count", done_cnt - d0, 1);
    check("restart_addr_left", exp_addr.size(), 0);

    // Reset after three pixels of a 4x2 frame
    rdy_mode = 0;
    d0 = done_cnt;
    p0 = pix_got;
    start_frame(4, 2, 22'h000300);
    n = 0;
    while (pix_got - p0 < 3 && n < 30) begin
      tick();
      n++;
    end
    check("abort_three_pixels", pix_got - p0, 3);
    Reset = 1'b1;
    tick();
    check_idle_outputs("abort");
    exp_pix.delete();
    exp_addr.delete();
    prev_stall = 1'b0;
    last_hs    = 1'b0;
    Reset      = 1'b0;
    repeat (10) tick();
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_busy", Busy, 0);

    // Table of frames with the model checking every read and pixel
    foreach (tbl[i]) begin
      rdy_mode = tbl[i].mode;
      d0 = done_cnt;
      p0 = pix_got;
      start_frame(tbl[i].w, tbl[i].h, tbl[i].base);
      wait_done(d0, tbl[i].w * tbl[i].h * 4 + 20, "tbl_done_seen");
      repeat (3) tick();
      check("tbl_pixels", pix_got - p0, tbl[i].exp_pix);
      check("tbl_done_count", done_cnt - d0, tbl[i].exp_done);
      check("tbl_model_drained", exp_pix.size() + exp_addr.size(), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
